draw_sequencer: RTL

Frame-level scheduler and pixel-port multiplexer that sits directly downstream of the per-object draw engines (player HP bar drawer, player sprite, bullets, background clear) and upstream of the VGA adapter's single plot port. On each frame tick it starts every enabled draw client in fixed index order, using the start/done handshake those engines implement. While a client runs, its x/y/colour/draw-enable are forwarded to the VGA port, and the block moves to the next client only after the handshake has fully closed. A watchdog bounds every client so a hung drawer cannot stall the frame.

---
 rtl/draw_pkg.sv | 13 +
 rtl/draw_port_mux.sv | 51 +++++
 rtl/draw_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared widths, FSM encoding and defaults for the frame draw sequencer.
package draw_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int DEF_TIMEOUT = 20000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } seq_state_e;
endpackage

// File: rtl/draw_port_mux.sv
// Registered N-way pixel-port mux: one client's draw_en/x/y/colour, selected
// by sel_i and gated by en_i, appears on the VGA plot port one cycle later.
module draw_port_mux import draw_pkg::*; #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] sel_i,
  input  logic [N-1:0]     draw_en_i,
  input  logic [N*X_W-1:0] x_i,
  input  logic [N*Y_W-1:0] y_i,
  input  logic [N*C_W-1:0] colour_i,
  output logic             plot_o,
  output logic [X_W-1:0]   x_o,
  output logic [Y_W-1:0]   y_o,
  output logic [C_W-1:0]   colour_o
);
  logic [N-1:0][X_W-1:0] x_a;
  logic [N-1:0][Y_W-1:0] y_a;
  logic [N-1:0][C_W-1:0] c_a;
  logic                  plot_q;
  logic [X_W-1:0]        x_q;
  logic [Y_W-1:0]        y_q;
  logic [C_W-1:0]        c_q;

  assign x_a = x_i;
  assign y_a = y_i;
  assign c_a = colour_i;

  // Coordinates follow the selected slice every cycle; only plot is qualified.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      plot_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      c_q    <= '0;
    end else begin
      plot_q <= en_i & draw_en_i[sel_i];
      x_q    <= x_a[sel_i];
      y_q    <= y_a[sel_i];
      c_q    <= c_a[sel_i];
    end
  end

  assign plot_o   = plot_q;
  assign x_o      = x_q;
  assign y_o      = y_q;
  assign colour_o = c_q;
endmodule

// File: rtl/draw_sequencer.sv
// Per-frame scheduler: starts each enabled draw client in index order with a
// start/done handshake and a per-phase watchdog, forwarding its pixels to VGA.
module draw_sequencer import draw_pkg::*; #(
  parameter int N_CLIENTS = 4,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     frame_tick_i,
  input  logic [N_CLIENTS-1:0]     client_en_i,
  output logic [N_CLIENTS-1:0]     start_o,
  input  logic [N_CLIENTS-1:0]     done_in_i,
  input  logic [N_CLIENTS-1:0]     draw_en_in_i,
  input  logic [8*N_CLIENTS-1:0]   x_in_i,
  input  logic [7*N_CLIENTS-1:0]   y_in_i,
  input  logic [3*N_CLIENTS-1:0]   colour_in_i,
  output logic                     plot_o,
  output logic [X_W-1:0]           x_out_o,
  output logic [Y_W-1:0]           y_out_o,
  output logic [C_W-1:0]           colour_out_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     timeout_err_o,
  output logic                     overrun_o
);
  localparam int              IDX_W    = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLIENTS - 1);
  localparam logic [15:0]     WD_LAST  = 16'(TIMEOUT - 1);

  seq_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_CLIENTS-1:0]   en_lat_q, en_lat_d;
  logic [15:0]            wdog_q, wdog_d;
  logic                   frame_done_q, frame_done_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;
  logic                   advance, wd_exp, run_en;

  assign wd_exp = (wdog_q == WD_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      en_lat_q     <= '0;
      wdog_q       <= '0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      en_lat_q     <= en_lat_d;
      wdog_q       <= wdog_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    en_lat_d     = en_lat_q;
    wdog_d       = (wdog_q == 16'hFFFF) ? wdog_q : wdog_q + 16'd1;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    advance      = 1'b0;
    overrun_d    = frame_tick_i && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (frame_tick_i) begin
          en_lat_d = client_en_i;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // A done arriving on the expiry cycle wins: the client finished in time.
        if (!en_lat_q[idx_q]) advance = 1'b1;
        else if (done_in_i[idx_q]) begin
          state_d = ST_RELEASE;
          wdog_d  = '0;
        end else if (wd_exp) begin
          timeout_d = 1'b1;
          state_d   = ST_RELEASE;
          wdog_d    = '0;
        end
      end
      ST_RELEASE: begin
        if (!done_in_i[idx_q]) advance = 1'b1;
        else if (wd_exp) begin
          timeout_d = 1'b1;
          advance   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) begin
      wdog_d = '0;
      if (idx_q == IDX_LAST) begin
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    run_en  = (state_q == ST_RUN) && en_lat_q[idx_q];
    start_o = '0;
    if (run_en) start_o[idx_q] = 1'b1;
    busy_o  = (state_q != ST_IDLE);
  end

  assign frame_done_o  = frame_done_q;
  assign timeout_err_o = timeout_q;
  assign overrun_o     = overrun_q;

  draw_port_mux #(.N(N_CLIENTS), .IDX_W(IDX_W)) u_mux (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (run_en),
    .sel_i     (idx_q),
    .draw_en_i (draw_en_in_i),
    .x_i       (x_in_i),
    .y_i       (y_in_i),
    .colour_i  (colour_in_i),
    .plot_o    (plot_o),
    .x_o       (x_out_o),
    .y_o       (y_out_o),
    .colour_o  (colour_out_o)
  );
endmodule
